mmio_uart: RTL
==============

Name: mmio_uart

Overview:
- Memory-mapped UART responder on the core's MMIO port (addr / wmask / wdata out, rdata in).
- The core is the only initiator; this block decodes a 16-byte window and answers reads with registered data.
- Serialises bytes on a TX pin and deserialises an RX pin into a small FIFO.
- Frame format is fixed 8N1, LSB first, idle-high line.

Parameters:
- BASE_ADDR, 32'h1000_0000, window base; only bits [31:4] are compared.
- DEFAULT_DIV, 16'd868, reset baud divisor in clk cycles per bit (100 MHz / 115200).
- RX_DEPTH, 4, RX FIFO entries; must be a power of 2, ≥2.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- mmio_i_addr  in  32  byte address from the core.
- mmio_i_wmask  in  4  byte write enables; nonzero means write this cycle.
- mmio_i_wdata  in  32  write data.
- mmio_o_rdata  out  32  registered read data.
- uart_o_tx  out  1  serial out.
- uart_i_rx  in  1  serial in, asynchronous to clk.

Behaviour:
- Decode: hit when addr[31:4]==BASE_ADDR[31:4]; register selected by addr[3:2]. A miss reads 0 and ignores writes.
- Reads: no strobe. mmio_o_rdata at edge N+1 holds register contents sampled before any write applied at edge N. Reads have no side effects.
- Writes: committed at the rising edge when wmask!=0.
- 0x0 TXDATA:
  - Write with wmask[0] loads wdata[7:0] into the 1-entry hold register if it is empty.
  - If the hold register is full, the byte is dropped and STATUS.tx_drop is set.
  - Reads return 0.
- 0x4 RXDATA:
  - Read returns {rx_empty,23'b0,head[7:0]}; head reads 0 when empty.
  - Any write (any wmask) pops the FIFO; a pop when empty is a no-op.
- 0x8 STATUS:
  - Read bits: [0] tx_busy, [1] tx_hold_full, [2] rx_nonempty, [3] rx_full, [4] rx_overrun, [5] frame_err, [6] tx_drop.
  - Bits [6:4] are sticky. A write with wmask[0] clears each of them whose wdata bit is 1 (write-1-to-clear).
- 0xC DIV:
  - [15:0] read/write with byte enables wmask[1:0]; upper bits read 0.
  - A resulting value <2 is stored as 2.
- Reset values: mmio_o_rdata=0; uart_o_tx=1; DIV=DEFAULT_DIV; FIFO empty; hold empty; all sticky bits 0; both FSMs IDLE.
- TX FSM IDLE→START→DATA→STOP→IDLE:
  - IDLE with hold full: the next edge moves hold into the shifter, empties hold, latches DIV, and enters START.
  - START drives 0 and STOP drives 1, each for DIV cycles. DATA drives 8 bits LSB first, DIV cycles each.
  - From STOP: go directly to START if hold is full, else IDLE. Back-to-back frames have no extra idle cycle.
  - tx_busy is 1 in every state except IDLE.
  - uart_o_tx is driven from a flop, with no glitches.
- RX input path: uart_i_rx passes a 2-FF synchroniser (reset value 1) before the FSM.
- RX FSM IDLE→START→DATA→STOP:
  - IDLE: a sampled 1→0 transition latches DIV and enters START.
  - START: wait DIV/2 cycles. If the line is still 0 go to DATA; otherwise it is a glitch, return to IDLE with no flags.
  - DATA: sample every DIV cycles, 8 bits LSB first.
  - STOP: sample after DIV cycles. 1 means push the byte; 0 means set frame_err and discard the byte. Return to IDLE either way.
- FIFO boundaries:
  - Push when full drops the byte and sets rx_overrun.
  - Push and pop on the same edge when full: the pop takes effect first, the push succeeds, no overrun.
  - Push and pop on the same edge when empty: the pop is a no-op, the push succeeds.
  - Pointers carry log2(RX_DEPTH)+1 bits and wrap naturally.
- DIV writes mid-frame do not affect the current frame; they apply from the next frame.
- Reset mid-frame aborts immediately: uart_o_tx goes to 1 asynchronously and any partial byte is lost.

Decomposition:
- Package mmio_uart_pkg:
  - register offsets (OFF_TXDATA, OFF_RXDATA, OFF_STATUS, OFF_DIV)
  - STATUS bit indices
  - TX/RX state encodings (IDLE, START, DATA, STOP)
  - DIV_MIN=2
- One sub-module, mmio_uart_fifo: synchronous FIFO with push, pop, din, head, empty, full, and async reset.
- The TX and RX FSMs stay in the top level.

Test Plan (DIV written to 4 unless stated):
- Reset → rdata=0, tx=1, read STATUS=0x0, read DIV=868; write DIV=1 → DIV reads 2.
- Write TXDATA=0xA5 → tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4; tx_busy=1 throughout, 0 after.
- Write 0x11, 0x22, 0x33 on consecutive cycles → 0x11 and 0x22 transmitted back-to-back, 0x33 dropped, STATUS.tx_drop=1; write STATUS=0x40 → tx_drop=0.
- Drive RX frames 0x3C and 0x7E at DIV=4 → STATUS[2]=1; RXDATA reads 0x3C, pop, reads 0x7E, pop, reads 0x8000_0000.
- Drive 5 RX frames with no pops (RX_DEPTH=4) → rx_full=1, rx_overrun=1, FIFO holds the first 4 bytes; pop on the same edge as the 5th push → no overrun.
- Stop bit driven 0 → frame_err=1, FIFO unchanged; 1-cycle low glitch on rx → no push, no flags; reset mid-TX → tx=1 immediately and STATUS=0.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the MMIO UART: register map, STATUS layout and FSM states.
package mmio_uart_pkg;

  localparam int unsigned DIV_W    = 16;
  localparam int unsigned STATUS_W = 7;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_RXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_DIV    = 2'd3;

  localparam int unsigned ST_TX_BUSY     = 0;
  localparam int unsigned ST_TX_HOLD     = 1;
  localparam int unsigned ST_RX_NONEMPTY = 2;
  localparam int unsigned ST_RX_FULL     = 3;
  localparam int unsigned ST_RX_OVERRUN  = 4;
  localparam int unsigned ST_FRAME_ERR   = 5;
  localparam int unsigned ST_TX_DROP     = 6;

  localparam logic [DIV_W-1:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

endpackage

// File: rtl/mmio_uart_fifo.sv
// Small synchronous FIFO; a pop on the same edge as a push into a full FIFO frees the slot first.
module mmio_uart_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart.sv
// MMIO-mapped 8N1 UART: one-byte TX hold register, RX FIFO, sticky error flags, runtime baud divisor.
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR   = 32'h1000_0000,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd868,
  parameter int unsigned      RX_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmio_i_addr,
  input  logic [3:0]  mmio_i_wmask,
  input  logic [31:0] mmio_i_wdata,
  output logic [31:0] mmio_o_rdata,
  output logic        uart_o_tx,
  input  logic        uart_i_rx
);

  logic             hit_c, wr_c, wr_tx_c, wr_status_c, wr_div_c, rx_pop_c;
  logic [1:0]       sel_c;
  logic [DIV_W-1:0] div, div_wr_c;
  logic [7:0]       hold;
  logic             hold_full, rx_overrun, frame_err, tx_drop;
  logic [STATUS_W-1:0] status_c;
  logic [31:0]      rdata_c;
  logic             fifo_empty, fifo_full;
  logic [7:0]       fifo_head;

  uart_state_e      tx_state, tx_state_d;
  logic [DIV_W-1:0] tx_cnt, tx_cnt_d, tx_div, tx_div_d;
  logic [2:0]       tx_bit, tx_bit_d;
  logic [7:0]       tx_shift, tx_shift_d;
  logic             tx_d, tx_take_c, tx_end_c;

  uart_state_e      rx_state, rx_state_d;
  logic [DIV_W-1:0] rx_cnt, rx_cnt_d, rx_div, rx_div_d;
  logic [2:0]       rx_bit, rx_bit_d;
  logic [7:0]       rx_shift, rx_shift_d;
  logic             rx_meta, rx_s, rx_prev, rx_push_c, rx_ferr_c, rx_end_c, rx_half_c;

  logic unused_bits;
  assign unused_bits = ^{mmio_i_addr[1:0], mmio_i_wdata[31:16]};

  assign hit_c       = (mmio_i_addr[31:4] == BASE_ADDR[31:4]);
  assign sel_c       = mmio_i_addr[3:2];
  assign wr_c        = hit_c && (mmio_i_wmask != 4'd0);
  assign wr_tx_c     = wr_c && (sel_c == OFF_TXDATA) && mmio_i_wmask[0];
  assign rx_pop_c    = wr_c && (sel_c == OFF_RXDATA);
  assign wr_status_c = wr_c && (sel_c == OFF_STATUS) && mmio_i_wmask[0];
  assign wr_div_c    = wr_c && (sel_c == OFF_DIV) && (mmio_i_wmask[1:0] != 2'd0);
  assign div_wr_c    = {mmio_i_wmask[1] ? mmio_i_wdata[15:8] : div[15:8],
                        mmio_i_wmask[0] ? mmio_i_wdata[7:0]  : div[7:0]};

  always_comb begin
    status_c                 = '0;
    status_c[ST_TX_BUSY]     = (tx_state != S_IDLE);
    status_c[ST_TX_HOLD]     = hold_full;
    status_c[ST_RX_NONEMPTY] = !fifo_empty;
    status_c[ST_RX_FULL]     = fifo_full;
    status_c[ST_RX_OVERRUN]  = rx_overrun;
    status_c[ST_FRAME_ERR]   = frame_err;
    status_c[ST_TX_DROP]     = tx_drop;
  end

  always_comb begin
    rdata_c = '0;
    if (hit_c) begin
      case (sel_c)
        OFF_RXDATA: rdata_c = {fifo_empty, 23'd0, fifo_empty ? 8'd0 : fifo_head};
        OFF_STATUS: rdata_c = 32'(status_c);
        OFF_DIV:    rdata_c = {16'd0, div};
        default:    rdata_c = '0;
      endcase
    end
  end

  // A write into the hold register is accepted when the TX FSM drains it on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmio_o_rdata <= '0;
      div          <= DEFAULT_DIV;
      hold         <= '0;
      hold_full    <= 1'b0;
      rx_overrun   <= 1'b0;
      frame_err    <= 1'b0;
      tx_drop      <= 1'b0;
    end else begin
      mmio_o_rdata <= rdata_c;
      if (wr_div_c) div <= (div_wr_c < DIV_MIN) ? DIV_MIN : div_wr_c;
      if (wr_tx_c && (!hold_full || tx_take_c)) begin
        hold      <= mmio_i_wdata[7:0];
        hold_full <= 1'b1;
      end else if (tx_take_c) begin
        hold_full <= 1'b0;
      end
      if (rx_push_c && fifo_full && !rx_pop_c) rx_overrun <= 1'b1;
      else if (wr_status_c && mmio_i_wdata[ST_RX_OVERRUN]) rx_overrun <= 1'b0;
      if (rx_ferr_c) frame_err <= 1'b1;
      else if (wr_status_c && mmio_i_wdata[ST_FRAME_ERR]) frame_err <= 1'b0;
      if (wr_tx_c && hold_full && !tx_take_c) tx_drop <= 1'b1;
      else if (wr_status_c && mmio_i_wdata[ST_TX_DROP]) tx_drop <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_div    <= DEFAULT_DIV;
      uart_o_tx <= 1'b1;
    end else begin
      tx_state  <= tx_state_d;
      tx_cnt    <= tx_cnt_d;
      tx_bit    <= tx_bit_d;
      tx_shift  <= tx_shift_d;
      tx_div    <= tx_div_d;
      uart_o_tx <= tx_d;
    end
  end

  // TX next state; the line level for the next bit is computed here and registered.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt + 16'd1;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    tx_div_d   = tx_div;
    tx_d       = uart_o_tx;
    tx_take_c  = 1'b0;
    tx_end_c   = (tx_cnt == tx_div - 16'd1);
    case (tx_state)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (hold_full) begin
          tx_take_c  = 1'b1;
          tx_shift_d = hold;
          tx_div_d   = div;
          tx_state_d = S_START;
          tx_d       = 1'b0;
        end
      end
      S_START: if (tx_end_c) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = S_DATA;
        tx_d       = tx_shift[0];
      end
      S_DATA: if (tx_end_c) begin
        tx_cnt_d = '0;
        if (tx_bit == 3'd7) begin
          tx_state_d = S_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_bit_d   = tx_bit + 3'd1;
          tx_shift_d = {1'b0, tx_shift[7:1]};
          tx_d       = tx_shift[1];
        end
      end
      S_STOP: if (tx_end_c) begin
        tx_cnt_d = '0;
        if (hold_full) begin
          tx_take_c  = 1'b1;
          tx_shift_d = hold;
          tx_div_d   = div;
          tx_state_d = S_START;
          tx_d       = 1'b0;
        end else begin
          tx_state_d = S_IDLE;
          tx_d       = 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_div   <= DEFAULT_DIV;
    end else begin
      rx_meta  <= uart_i_rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
      rx_div   <= rx_div_d;
    end
  end

  // RX next state: qualify the start bit at half a bit time, then sample once per bit.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + 16'd1;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_div_d   = rx_div;
    rx_push_c  = 1'b0;
    rx_ferr_c  = 1'b0;
    rx_end_c   = (rx_cnt == rx_div - 16'd1);
    rx_half_c  = (rx_cnt == (rx_div >> 1) - 16'd1);
    case (rx_state)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev && !rx_s) begin
          rx_div_d   = div;
          rx_state_d = S_START;
        end
      end
      S_START: if (rx_half_c) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_end_c) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s, rx_shift[7:1]};
        rx_bit_d   = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_d = S_STOP;
      end
      S_STOP: if (rx_end_c) begin
        rx_cnt_d   = '0;
        rx_push_c  = rx_s;
        rx_ferr_c  = !rx_s;
        rx_state_d = S_IDLE;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  mmio_uart_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push_c),
    .pop   (rx_pop_c),
    .din   (rx_shift),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule
